// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, data word, and the memory arbiter FSM encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned ARB_CNT_W = 8;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DLOCK = 2'd1,
        ILOCK = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port RAM between fetch and data access, data first, with a sticky watchdog.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LAT_MAX = 15
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  ramstate_t         ramstate,
    output logic              tout,
    output word_t             icnt,
    output word_t             dcnt,
    output word_t             scnt
);

    localparam logic [ARB_CNT_W-1:0] LAT_MAX_C = ARB_CNT_W'(LAT_MAX);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [ARB_CNT_W-1:0]   r_cnt;
    logic [ARB_CNT_W-1:0]   w_cnt_nxt;
    logic                   r_tout;
    logic                   w_dreq;
    logic                   w_access;
    logic                   w_down;
    logic                   w_iown;
    logic                   w_iblock;
    logic                   w_dblock;
    logic                   w_icomp;
    logic                   w_dcomp;

    assign w_dreq   = dREN | dWEN;
    assign w_access = (ramstate == ACCESS);
    assign iload    = ramload;
    assign dload    = ramload;
    assign tout     = r_tout;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tout  <= r_tout | (w_cnt_nxt == LAT_MAX_C);
        end
    end

    // Grant selection, completion and next state; a locked grant ends on ACCESS or on abort.
    always_comb begin
        w_state_nxt = r_state;
        w_down      = 1'b0;
        w_iown      = 1'b0;
        w_iblock    = 1'b0;
        w_dblock    = 1'b0;
        w_icomp     = 1'b0;
        w_dcomp     = 1'b0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = dstore;

        case (r_state)
            IDLE: begin
                if (w_dreq) begin
                    w_down      = 1'b1;
                    w_dcomp     = w_access;
                    w_state_nxt = w_access ? IDLE : DLOCK;
                end else if (iREN) begin
                    w_iown      = 1'b1;
                    w_icomp     = w_access;
                    w_state_nxt = w_access ? IDLE : ILOCK;
                end
            end
            DLOCK: begin
                w_iblock = 1'b1;
                if (w_dreq) begin
                    w_down  = 1'b1;
                    w_dcomp = w_access;
                    if (w_access) w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ILOCK: begin
                w_dblock = 1'b1;
                if (iREN) begin
                    w_iown  = 1'b1;
                    w_icomp = w_access;
                    if (w_access) w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // A combined read+write request is a write.
        if (w_down) begin
            ramWEN  = dWEN;
            ramREN  = ~dWEN;
            ramaddr = daddr;
        end else if (w_iown) begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
        end

        iwait = w_iblock | (iREN & ~w_icomp);
        dwait = w_dblock | (w_dreq & ~w_dcomp);

        if (!nRST) begin
            ramREN  = 1'b0;
            ramWEN  = 1'b0;
            iwait   = 1'b1;
            dwait   = 1'b1;
            w_icomp = 1'b0;
            w_dcomp = 1'b0;
        end
    end

    // Watchdog counts locked cycles, saturating at LAT_MAX.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_state_nxt == IDLE || r_state == IDLE) begin
            w_cnt_nxt = '0;
        end else if (r_cnt < LAT_MAX_C) begin
            w_cnt_nxt = r_cnt + ARB_CNT_W'(1);
        end
    end

`ifdef MEM_ARB_PERF_EN
    word_t r_icnt;
    word_t r_dcnt;
    word_t r_scnt;
    logic  w_stall;

    assign w_stall = (iwait & iREN) | (dwait & w_dreq);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_icnt <= '0;
            r_dcnt <= '0;
            r_scnt <= '0;
        end else begin
            if (w_icomp) r_icnt <= r_icnt + WORD_W'(1);
            if (w_dcomp) r_dcnt <= r_dcnt + WORD_W'(1);
            if (w_stall) r_scnt <= r_scnt + WORD_W'(1);
        end
    end

    assign icnt = r_icnt;
    assign dcnt = r_dcnt;
    assign scnt = r_scnt;
`else
    assign icnt = '0;
    assign dcnt = '0;
    assign scnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (LAT_MAX=4); expectations hand-derived.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    ramstate_t   ramstate;
    logic        tout;
    word_t       icnt;
    word_t       dcnt;
    word_t       scnt;

    int n_checks;
    int n_errors;

    mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .LAT_MAX (4)
    ) u_dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .tout     (tout),
        .icnt     (icnt),
        .dcnt     (dcnt),
        .scnt     (scnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One transaction with a single BUSY cycle, then ACCESS, then an idle cycle.
    task automatic txn(input logic is_data, input logic [31:0] addr);
        if (is_data) begin dREN = 1'b1; daddr = addr; end
        else begin iREN = 1'b1; iaddr = addr; end
        ramstate = BUSY;
        tick();
        ramstate = ACCESS;
        #2;
        check(is_data ? "perf_dwait" : "perf_iwait", 32'(is_data ? dwait : iwait), 32'd0);
        tick();
        dREN = 1'b0; iREN = 1'b0; ramstate = FREE;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_i;
        logic [31:0] exp_d;
        logic [31:0] exp_s;
        n_checks = 0;
        n_errors = 0;
        nRST = 1'b0; iREN = 1'b1; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

        // 1: reset holds outputs, then zero-latency fetch
        #2;
        check("rst_ramren", 32'(ramREN), 32'd0);
        check("rst_iwait",  32'(iwait),  32'd1);
        check("rst_dwait",  32'(dwait),  32'd1);
        check("rst_tout",   32'(tout),   32'd0);
        check("rst_icnt",   icnt,        32'd0);
        tick(); tick();
        nRST = 1'b1; ramstate = ACCESS; ramload = 32'h1234_5678;
        #2;
        check("zl_iwait",   32'(iwait),  32'd0);
        check("zl_iload",   iload,       32'h1234_5678);
        check("zl_ramren",  32'(ramREN), 32'd1);
        check("zl_ramaddr", ramaddr,     32'h0);
        tick();
        iREN = 1'b0; ramstate = FREE;
        #2;
        check("idle_iwait", 32'(iwait), 32'd0);
        check("idle_dwait", 32'(dwait), 32'd0);
        tick();

        // 2: contention, data wins and holds for three cycles
        iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h100; ramstate = BUSY;
        #2;
        check("ct0_ramaddr", ramaddr,     32'h100);
        check("ct0_dwait",   32'(dwait),  32'd1);
        check("ct0_iwait",   32'(iwait),  32'd1);
        tick();
        #2;
        check("ct1_ramaddr", ramaddr,     32'h100);
        check("ct1_iwait",   32'(iwait),  32'd1);
        tick();
        ramstate = ACCESS; ramload = 32'h0000_CAFE;
        #2;
        check("ct2_ramaddr", ramaddr,     32'h100);
        check("ct2_dwait",   32'(dwait),  32'd0);
        check("ct2_dload",   dload,       32'h0000_CAFE);
        check("ct2_iwait",   32'(iwait),  32'd1);
        tick();
        dREN = 1'b0; ramstate = BUSY;
        #2;
        check("ct3_ramaddr", ramaddr,     32'h40);
        check("ct3_iwait",   32'(iwait),  32'd1);
        tick();

        // 3: fetch lock ignores a late write until ACCESS
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
        #2;
        check("lk0_ramaddr", ramaddr,     32'h40);
        check("lk0_ramwen",  32'(ramWEN), 32'd0);
        check("lk0_dwait",   32'(dwait),  32'd1);
        tick();
        ramstate = ACCESS;
        #2;
        check("lk1_ramaddr", ramaddr,     32'h40);
        check("lk1_iwait",   32'(iwait),  32'd0);
        check("lk1_dwait",   32'(dwait),  32'd1);
        tick();
        iREN = 1'b0;
        #2;
        check("wr_ramwen",   32'(ramWEN), 32'd1);
        check("wr_ramaddr",  ramaddr,     32'h200);
        check("wr_ramstore", ramstore,    32'hDEAD_BEEF);
        check("wr_dwait",    32'(dwait),  32'd0);
        tick();
        dWEN = 1'b0; ramstate = FREE;
        #2;
        check("wr_tout", 32'(tout), 32'd0);
        tick();

        // 4: read+write is a write; dropping the request aborts
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h300; ramstate = BUSY;
        #2;
        check("rw_ramwen", 32'(ramWEN), 32'd1);
        check("rw_ramren", 32'(ramREN), 32'd0);
        check("rw_dwait",  32'(dwait),  32'd1);
        tick();
        dREN = 1'b0; dWEN = 1'b0;
        #2;
        check("ab_ramren", 32'(ramREN), 32'd0);
        check("ab_ramwen", 32'(ramWEN), 32'd0);
        check("ab_iwait",  32'(iwait),  32'd1);
        tick();
        iREN = 1'b1; iaddr = 32'h80; ramstate = ACCESS;
        #2;
        check("ab_idle_ramaddr", ramaddr,    32'h80);
        check("ab_idle_iwait",   32'(iwait), 32'd0);
        tick();

        // 5: watchdog with LAT_MAX=4
        iaddr = 32'h500; ramstate = BUSY;
        #2;
        check("wd_l0_tout", 32'(tout), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            #2;
            check("wd_lk_tout", 32'(tout), 32'd0);
        end
        tick();
        #2;
        check("wd_tout_set",  32'(tout),   32'd1);
        check("wd_grant",     32'(ramREN), 32'd1);
        check("wd_grantaddr", ramaddr,     32'h500);
        ramstate = ACCESS;
        #1;
        check("wd_iwait", 32'(iwait), 32'd0);
        tick();
        iREN = 1'b0; ramstate = FREE;
        #2;
        check("wd_sticky", 32'(tout), 32'd1);
        tick();
        nRST = 1'b0;
        #1;
        check("wd_rst_tout", 32'(tout), 32'd0);
        tick();
        nRST = 1'b1;
        tick();

        // 6: performance counters
        txn(1'b0, 32'h10);
        txn(1'b0, 32'h14);
        txn(1'b0, 32'h18);
        txn(1'b1, 32'h20);
        txn(1'b1, 32'h24);
`ifdef MEM_ARB_PERF_EN
        exp_i = 32'd3; exp_d = 32'd2; exp_s = 32'd5;
`else
        exp_i = 32'd0; exp_d = 32'd0; exp_s = 32'd0;
`endif
        check("perf_icnt", icnt, exp_i);
        check("perf_dcnt", dcnt, exp_d);
        check("perf_scnt", scnt, exp_s);

        // ERROR keeps the grant and the stall
        iREN = 1'b1; iaddr = 32'h600; ramstate = ERROR;
        #2;
        check("err0_iwait", 32'(iwait), 32'd1);
        tick();
        dREN = 1'b1; daddr = 32'h700;
        #2;
        check("err1_iwait",   32'(iwait), 32'd1);
        check("err1_ramaddr", ramaddr,    32'h600);
        check("err1_dwait",   32'(dwait), 32'd1);
        tick();
        ramstate = ACCESS;
        #2;
        check("err2_iwait", 32'(iwait), 32'd0);
        tick();
        iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
